// File: rtl/muldiv_pkg.sv
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared funct3 codes, FSM state encoding and special-case
//                result helper for the RV32M multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam int MD_ITER = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] value;
    } md_special_t;

    // Divide-by-zero and signed-overflow results mandated by RISC-V.
    function automatic md_special_t md_special(input logic [2:0]  op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        md_special_t s;
        s.hit   = 1'b0;
        s.value = '0;
        if (op[2]) begin
            if (b == 32'h0) begin
                s.hit   = 1'b1;
                s.value = op[1] ? a : 32'hFFFF_FFFF;
            end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                s.hit   = 1'b1;
                s.value = op[1] ? 32'h0 : 32'h8000_0000;
            end
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Iterative RV32M controller: 32-step shift-add multiply and
//                restoring divide, stalling the pipeline while it runs.
//                Build option MULDIV_EARLY_OUT_EN finishes special cases in PREP.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = MD_ITER
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int c_CNT_W = $clog2(ITER);

    md_state_t          r_state;
    logic [2:0]         r_op;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [XLEN-1:0]    r_mag_a;
    logic [XLEN-1:0]    r_mag_b;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [c_CNT_W-1:0] r_count;
    logic               r_busy;
    logic               r_done;
    logic [XLEN-1:0]    r_result;

    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    md_special_t        w_special;
    logic [XLEN:0]      w_sum;
    logic [XLEN:0]      w_rem_sh;
    logic               w_ge;
    logic [XLEN-1:0]    w_rem_sub;
    logic [2*XLEN-1:0]  w_prod;
    logic [2*XLEN-1:0]  w_prod_s;
    logic [XLEN-1:0]    w_quo;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_fix;

    assign w_a_signed = (r_op == MD_MUL) || (r_op == MD_MULH) || (r_op == MD_MULHSU) ||
                        (r_op == MD_DIV) || (r_op == MD_REM);
    assign w_b_signed = (r_op == MD_MUL) || (r_op == MD_MULH) ||
                        (r_op == MD_DIV) || (r_op == MD_REM);
    assign w_neg_a    = w_a_signed & r_a[XLEN-1];
    assign w_neg_b    = w_b_signed & r_b[XLEN-1];
    assign w_mag_a    = w_neg_a ? (~r_a + 1'b1) : r_a;
    assign w_mag_b    = w_neg_b ? (~r_b + 1'b1) : r_b;
    assign w_special  = md_special(r_op, r_a, r_b);

    // Multiply step: conditional add into hi with carry, then 65-bit shift right.
    assign w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_a} : '0);

    // Divide step: the partial remainder always stays below |b|, so XLEN bits hold it.
    assign w_rem_sh   = {r_hi, r_lo[XLEN-1]};
    assign w_ge       = w_rem_sh >= {1'b0, r_mag_b};
    assign w_rem_sub  = w_rem_sh[XLEN-1:0] - r_mag_b;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_s   = (r_neg_a ^ r_neg_b) ? (~w_prod + 1'b1) : w_prod;
    assign w_quo      = (r_neg_a ^ r_neg_b) ? (~r_lo + 1'b1) : r_lo;
    assign w_rem      = r_neg_a ? (~r_hi + 1'b1) : r_hi;

    always_comb begin
        w_fix = '0;
        if (!r_op[2]) begin
            w_fix = (r_op == MD_MUL) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
        end else begin
            w_fix = r_op[1] ? w_rem : w_quo;
        end
        if (w_special.hit) begin
            w_fix = w_special.value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_op    <= op;
                            r_a     <= operand_a;
                            r_b     <= operand_b;
                            r_busy  <= 1'b1;
                            r_state <= PREP;
                        end
                    end
                    PREP: begin
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_hi    <= '0;
                        r_lo    <= r_op[2] ? w_mag_a : w_mag_b;
                        r_count <= c_CNT_W'(ITER - 1);
`ifdef MULDIV_EARLY_OUT_EN
                        if (w_special.hit) begin
                            r_result <= w_special.value;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= CALC;
                        end
`else
                        r_state <= CALC;
`endif
                    end
                    CALC: begin
                        if (!r_op[2]) begin
                            r_hi <= w_sum[XLEN:1];
                            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                        end else begin
                            r_hi <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_ge};
                        end
                        if (r_count == '0) begin
                            r_state <= FIX;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    FIX: begin
                        r_result <= w_fix;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign stall_req = r_busy | (start & (r_state == IDLE));

endmodule

`default_nettype wire
